// File: rtl/vdc_cpu_port.sv
// HuC6270 VDC CPU-side port: bus-cycle decode, AR/register commits, MAWR/MARR, VRAM access FSM.
// Optional VDC_PORT_ERR_EN adds a sticky err output flagging VRAM starts dropped while busy.
module vdc_cpu_port #(
    parameter int AW = 16,
    parameter int RW = 5
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          cs_n,
    input  logic          wr_n,
    input  logic          rd_n,
    input  logic [1:0]    a,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          busy_n,
    input  logic [7:0]    status,
    output logic          status_rd,
    output logic          reg_we,
    output logic [RW-1:0] reg_addr,
    output logic [15:0]   reg_wdata,
    output logic          vram_req,
    output logic          vram_we,
    output logic [AW-1:0] vram_addr,
    output logic [15:0]   vram_wdata,
    input  logic          vram_ack,
    input  logic [15:0]   vram_rdata
`ifdef VDC_PORT_ERR_EN
    ,
    output logic          err
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

    state_t        state, state_nx;
    logic          cs_q, wr_q, rd_q;
    logic [1:0]    a_q;
    logic [7:0]    din_q;
    logic [RW-1:0] ar;
    logic [7:0]    lo;
    logic [AW-1:0] mawr, marr, marr_nx, rd_addr, inc;
    logic [15:0]   vrr;
    logic [1:0]    inc_sel;

    logic          wr_ev, rd_ev, commit, start_wr, start_rd, idle;
    logic [15:0]   w_word;

    // CPU strobes act on their rising edge; a write in the same cycle suppresses the read.
    assign wr_ev    = wr_n & ~wr_q & ~cs_q;
    assign rd_ev    = rd_n & ~rd_q & ~cs_q & ~wr_ev;
    assign commit   = wr_ev && (a_q == 2'd3);
    assign w_word   = {din_q, lo};
    assign idle     = (state == S_IDLE);
    assign start_wr = commit && (ar == RW'(2));
    assign start_rd = (commit && (ar == RW'(1))) ||
                      (rd_ev && (a_q == 2'd3) && (ar == RW'(2)));
    assign marr_nx  = marr + inc;
    assign rd_addr  = commit ? AW'(w_word) : marr_nx;

    always_comb begin
        inc = AW'(1);
        case (inc_sel)
            2'b00: inc = AW'(1);
            2'b01: inc = AW'(32);
            2'b10: inc = AW'(64);
            2'b11: inc = AW'(128);
            default: inc = AW'(1);
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    // Starts are only accepted from IDLE; anything arriving while busy is dropped.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start_wr)      state_nx = S_WRITE;
                else if (start_rd) state_nx = S_READ;
            end
            S_WRITE: if (vram_ack) state_nx = S_IDLE;
            S_READ:  if (vram_ack) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // VRAM handshake: vram_req is held with addr/we/wdata stable until the cycle
    // vram_ack is high; the request drops on the following cycle.
    always_comb begin
        busy_n   = (state == S_IDLE);
        vram_req = (state != S_IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cs_q       <= 1'b1;
            wr_q       <= 1'b1;
            rd_q       <= 1'b1;
            a_q        <= '0;
            din_q      <= '0;
            ar         <= '0;
            lo         <= '0;
            mawr       <= '0;
            marr       <= '0;
            vrr        <= '0;
            inc_sel    <= '0;
            dout       <= '0;
            status_rd  <= 1'b0;
            reg_we     <= 1'b0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            vram_we    <= 1'b0;
            vram_addr  <= '0;
            vram_wdata <= '0;
        end else begin
            cs_q  <= cs_n;
            wr_q  <= wr_n;
            rd_q  <= rd_n;
            a_q   <= a;
            din_q <= din;

            if (wr_ev && (a_q == 2'd0)) ar <= din_q[RW-1:0];
            if (wr_ev && (a_q == 2'd2)) lo <= din_q;

            reg_we <= commit;
            if (commit) begin
                reg_addr  <= ar;
                reg_wdata <= w_word;
            end
            if (commit && (ar == '0))       mawr    <= AW'(w_word);
            if (commit && (ar == RW'(5)))   inc_sel <= w_word[12:11];
            if (start_rd)                   marr    <= rd_addr;

            // Post-increment wins over a same-cycle MAWR commit.
            if ((state == S_WRITE) && vram_ack) mawr <= vram_addr + inc;
            if ((state == S_READ) && vram_ack)  vrr  <= vram_rdata;

            if (idle && start_wr) begin
                vram_we    <= 1'b1;
                vram_addr  <= mawr;
                vram_wdata <= w_word;
            end else if (idle && start_rd) begin
                vram_we   <= 1'b0;
                vram_addr <= rd_addr;
            end

            status_rd <= rd_ev && (a_q == 2'd0);

            if (!cs_n && !rd_n) begin
                case (a)
                    2'd0: dout <= status;
                    2'd1: dout <= 8'h00;
                    2'd2: dout <= vrr[7:0];
                    2'd3: dout <= vrr[15:8];
                    default: dout <= 8'h00;
                endcase
            end
        end
    end

`ifdef VDC_PORT_ERR_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err <= 1'b0;
        end else begin
            if (wr_ev && (a_q == 2'd1) && din_q[0]) err <= 1'b0;
            if (!idle && (start_wr || start_rd))    err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_vdc_cpu_port.sv
// Scoreboard bench for vdc_cpu_port: directed CPU bus cycles, expected commits and VRAM
// transactions queued at issue time and checked by a negedge monitor.
module tb_vdc_cpu_port;

    localparam int AW = 16;
    localparam int RW = 5;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          cs_n = 1'b1, wr_n = 1'b1, rd_n = 1'b1;
    logic [1:0]    a = 2'd0;
    logic [7:0]    din = 8'h00;
    logic [7:0]    dout;
    logic          busy_n;
    logic [7:0]    status = 8'hA5;
    logic          status_rd;
    logic          reg_we;
    logic [RW-1:0] reg_addr;
    logic [15:0]   reg_wdata;
    logic          vram_req, vram_we;
    logic [AW-1:0] vram_addr;
    logic [15:0]   vram_wdata;
    logic          vram_ack = 1'b0;
    logic [15:0]   vram_rdata = 16'h0000;
`ifdef VDC_PORT_ERR_EN
    logic          err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // {addr[4:0], wdata[15:0]}
    logic [20:0] exp_reg_q[$];
    // {len[7:0], we, addr[15:0], wdata[15:0]}
    logic [40:0] exp_vram_q[$];

    int          ack_delay = 3;
    logic [15:0] rd_val = 16'h0000;
    int          req_cycles = 0;
    int          req_len = 0;
    int          st_pulses = 0;
    logic [20:0] e_reg;
    logic [40:0] e_vram;

    vdc_cpu_port #(.AW(AW), .RW(RW)) dut (
        .clock(clock), .reset_n(reset_n), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n),
        .a(a), .din(din), .dout(dout), .busy_n(busy_n), .status(status),
        .status_rd(status_rd), .reg_we(reg_we), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .vram_req(vram_req), .vram_we(vram_we),
        .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_ack(vram_ack),
        .vram_rdata(vram_rdata)
`ifdef VDC_PORT_ERR_EN
        , .err(err)
`endif
    );

    // clock / reset
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // VRAM model: acks ack_delay cycles into each request
    initial begin
        forever begin
            @(posedge clock); #1;
            vram_ack = 1'b0;
            if (vram_req) begin
                req_cycles++;
                if (req_cycles >= ack_delay) begin
                    vram_ack   = 1'b1;
                    vram_rdata = rd_val;
                    req_cycles = 0;
                end
            end else begin
                req_cycles = 0;
            end
        end
    end

    // monitor / scoreboard
    always @(negedge clock) begin
        if (reg_we) begin
            if (exp_reg_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL reg_we_unexpected: got addr %0h data %0h expected no commit", reg_addr, reg_wdata);
            end else begin
                e_reg = exp_reg_q.pop_front();
                chk("reg_addr", 64'(reg_addr), 64'(e_reg[20:16]));
                chk("reg_wdata", 64'(reg_wdata), 64'(e_reg[15:0]));
            end
        end
        if (vram_req) begin
            req_len++;
            chk("busy_n_during_req", 64'(busy_n), 64'd0);
            if (vram_ack) begin
                if (exp_vram_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL vram_unexpected: got addr %0h we %0h expected no access", vram_addr, vram_we);
                end else begin
                    e_vram = exp_vram_q.pop_front();
                    chk("vram_len", 64'(req_len), 64'(e_vram[40:33]));
                    chk("vram_we", 64'(vram_we), 64'(e_vram[32]));
                    chk("vram_addr", 64'(vram_addr), 64'(e_vram[31:16]));
                    if (e_vram[32]) chk("vram_wdata", 64'(vram_wdata), 64'(e_vram[15:0]));
                end
                req_len = 0;
            end
        end else begin
            req_len = 0;
        end
        if (status_rd) st_pulses++;
    end

    // driver tasks, entered and left at posedge+1
    task automatic cpu_wr(input logic [1:0] ad, input logic [7:0] d);
        cs_n = 1'b0; wr_n = 1'b0; a = ad; din = d;
        @(posedge clock); #1;
        wr_n = 1'b1; cs_n = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic cpu_rd(input logic [1:0] ad);
        cs_n = 1'b0; rd_n = 1'b0; a = ad;
        @(posedge clock); #1;
        rd_n = 1'b1; cs_n = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy_n !== 1'b1 && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        chk(name, 64'(busy_n), 64'd1);
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk("rst_dout", 64'(dout), 64'd0);
        chk("rst_busy_n", 64'(busy_n), 64'd1);
        chk("rst_vram_req", 64'(vram_req), 64'd0);
        chk("rst_reg_we", 64'(reg_we), 64'd0);
        chk("rst_status_rd", 64'(status_rd), 64'd0);
        chk("rst_vram_addr", 64'(vram_addr), 64'd0);
`ifdef VDC_PORT_ERR_EN
        chk("rst_err", 64'(err), 64'd0);
`endif
        reset_n = 1'b1;
        @(posedge clock); #1;

        // MAWR load
        exp_reg_q.push_back({5'd0, 16'h1234});
        cpu_wr(2'd0, 8'h00); cpu_wr(2'd2, 8'h34); cpu_wr(2'd3, 8'h12);

        // VRAM write through AR=2, then a second one proves MAWR post-increment
        cpu_wr(2'd0, 8'h02);
        ack_delay = 3;
        exp_reg_q.push_back({5'd2, 16'hABCD});
        exp_vram_q.push_back({8'd3, 1'b1, 16'h1234, 16'hABCD});
        cpu_wr(2'd2, 8'hCD); cpu_wr(2'd3, 8'hAB);
        chk("busy_n_low_after_start", 64'(busy_n), 64'd0);
        wait_idle("idle_after_wr1");
        exp_reg_q.push_back({5'd2, 16'h2211});
        exp_vram_q.push_back({8'd3, 1'b1, 16'h1235, 16'h2211});
        cpu_wr(2'd2, 8'h11); cpu_wr(2'd3, 8'h22);
        wait_idle("idle_after_wr2");

        // +64 increment with address wrap
        cpu_wr(2'd0, 8'h05);
        exp_reg_q.push_back({5'd5, 16'h1000});
        cpu_wr(2'd2, 8'h00); cpu_wr(2'd3, 8'h10);
        cpu_wr(2'd0, 8'h00);
        exp_reg_q.push_back({5'd0, 16'hFFF0});
        cpu_wr(2'd2, 8'hF0); cpu_wr(2'd3, 8'hFF);
        cpu_wr(2'd0, 8'h02);
        exp_reg_q.push_back({5'd2, 16'h5566});
        exp_vram_q.push_back({8'd3, 1'b1, 16'hFFF0, 16'h5566});
        cpu_wr(2'd2, 8'h66); cpu_wr(2'd3, 8'h55);
        wait_idle("idle_after_wrap_wr");
        exp_reg_q.push_back({5'd2, 16'h7788});
        exp_vram_q.push_back({8'd3, 1'b1, 16'h0030, 16'h7788});
        cpu_wr(2'd2, 8'h88); cpu_wr(2'd3, 8'h77);
        wait_idle("idle_after_wrap_chk");

        // reads: MARR load, VRR readback, auto-increment read
        cpu_wr(2'd0, 8'h05);
        exp_reg_q.push_back({5'd5, 16'h0000});
        cpu_wr(2'd2, 8'h00); cpu_wr(2'd3, 8'h00);
        cpu_wr(2'd0, 8'h01);
        rd_val = 16'hBEEF;
        exp_reg_q.push_back({5'd1, 16'h0200});
        exp_vram_q.push_back({8'd3, 1'b0, 16'h0200, 16'h0000});
        cpu_wr(2'd2, 8'h00); cpu_wr(2'd3, 8'h02);
        wait_idle("idle_after_rd1");
        cpu_wr(2'd0, 8'h02);
        cpu_rd(2'd2);
        chk("dout_vrr_lo", 64'(dout), 64'hEF);
        rd_val = 16'h1357;
        exp_vram_q.push_back({8'd3, 1'b0, 16'h0201, 16'h0000});
        cpu_rd(2'd3);
        chk("dout_vrr_hi", 64'(dout), 64'hBE);
        chk("busy_n_after_rd_inc", 64'(busy_n), 64'd0);
        wait_idle("idle_after_rd2");
        cpu_rd(2'd2);
        chk("dout_vrr_lo2", 64'(dout), 64'h57);
        cpu_rd(2'd1);
        chk("dout_a1", 64'(dout), 64'h00);
        cpu_rd(2'd0);
        chk("dout_status", 64'(dout), 64'hA5);
        chk("status_rd_pulse", 64'(status_rd), 64'd1);
        @(posedge clock); #1;
        chk("status_rd_one_cycle", 64'(status_rd), 64'd0);

        // start while busy is dropped; commit still reported
        ack_delay = 12;
        exp_reg_q.push_back({5'd2, 16'h0102});
        exp_vram_q.push_back({8'd12, 1'b1, 16'h0070, 16'h0102});
        cpu_wr(2'd2, 8'h02); cpu_wr(2'd3, 8'h01);
        exp_reg_q.push_back({5'd2, 16'h0304});
        cpu_wr(2'd2, 8'h04); cpu_wr(2'd3, 8'h03);
`ifdef VDC_PORT_ERR_EN
        chk("err_set_on_drop", 64'(err), 64'd1);
        cpu_wr(2'd1, 8'h01);
        chk("err_cleared", 64'(err), 64'd0);
`endif
        wait_idle("idle_after_drop");

        // asynchronous reset in the middle of a read
        ack_delay = 20;
        cpu_wr(2'd0, 8'h01);
        exp_reg_q.push_back({5'd1, 16'h0040});
        cpu_wr(2'd2, 8'h40); cpu_wr(2'd3, 8'h00);
        @(posedge clock); #1;
        chk("req_before_reset", 64'(vram_req), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_vram_req", 64'(vram_req), 64'd0);
        chk("arst_busy_n", 64'(busy_n), 64'd1);
        chk("arst_reg_addr", 64'(reg_addr), 64'd0);
        chk("arst_reg_wdata", 64'(reg_wdata), 64'd0);
        chk("arst_vram_addr", 64'(vram_addr), 64'd0);
        chk("arst_dout", 64'(dout), 64'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        ack_delay = 3;
        @(posedge clock); #1;

        // AR, lo, MAWR, VRR back at zero after reset
        cpu_rd(2'd2);
        chk("vrr_cleared", 64'(dout), 64'h00);
        exp_reg_q.push_back({5'd0, 16'h1100});
        cpu_wr(2'd3, 8'h11);
        cpu_wr(2'd0, 8'h02);
        exp_reg_q.push_back({5'd2, 16'h4400});
        exp_vram_q.push_back({8'd3, 1'b1, 16'h1100, 16'h4400});
        cpu_wr(2'd3, 8'h44);
        wait_idle("idle_after_reset_wr");

        repeat (5) @(posedge clock);
        #1;
        chk("reg_q_drained", 64'(exp_reg_q.size()), 64'd0);
        chk("vram_q_drained", 64'(exp_vram_q.size()), 64'd0);
        chk("status_rd_count", 64'(st_pulses), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vdc_cpu_port.md
Name: vdc_cpu_port

Overview:
- CPU-side host interface of the HuC6270 VDC. Sits directly upstream of the VDC register file and VRAM arbiter.
- Decodes 8-bit CPU bus cycles into three things:
  - Address-register (AR) updates.
  - Low-byte latching.
  - 16-bit register commits.
- Owns MAWR/MARR, auto-increment, VRAM read prefetch and the busy handshake toward the CPU.

Parameters:
AW, 16, VRAM word-address width
RW, 5, AR/register-select width

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cs_n  in  1  chip select, active low, synchronous to clock
wr_n  in  1  write strobe, active low
rd_n  in  1  read strobe, active low
a  in  2  CPU port select
din  in  8  CPU write data
dout  out  8  CPU read data
busy_n  out  1  low while a VRAM access is pending
status  in  8  status byte supplied by the status block
status_rd  out  1  one-cycle pulse on completed status read
reg_we  out  1  one-cycle register-commit strobe
reg_addr  out  RW  register index of the commit
reg_wdata  out  16  committed word
vram_req  out  1  VRAM access request
vram_we  out  1  1=write, 0=read
vram_addr  out  AW  VRAM word address
vram_wdata  out  16  VRAM write word
vram_ack  in  1  access accepted/completed this cycle
vram_rdata  in  16  read data, valid when vram_ack && !vram_we

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Input sampling: cs_n, wr_n, rd_n, a and din are registered every cycle into cs_q, wr_q, rd_q, a_q and din_q.
- Write event: wr_n==1 && wr_q==0 && cs_q==0. The event uses a_q and din_q.
- Read event: rd_n==1 && rd_q==0 && cs_q==0.
- Simultaneous write and read events in the same cycle: write processed, read ignored.
- Write by a_q:
  - 0: AR <= din_q[4:0].
  - 1: ignored.
  - 2: lo <= din_q.
  - 3: commit W={din_q,lo} to AR.
- Every commit: the following cycle, reg_we=1, reg_addr=AR, reg_wdata=W. Additional action by AR:
  - AR=0: MAWR<=W.
  - AR=1: MARR<=W, then start a read at W.
  - AR=2: start a write of W at MAWR.
  - AR=5: inc_sel<=W[12:11].
- Increment: inc_sel 00/01/10/11 gives +1/+32/+64/+128. Address arithmetic is modulo 2^AW.
- Read event with a_q=3 and AR=2: MARR<=MARR+inc, then start a read at the new MARR.
- Read event with a_q=0: status_rd pulses for one cycle.
- dout: registered; updated every cycle while cs_n==0 && rd_n==0, holds otherwise.
  - a=0 → status.
  - a=2 → VRR[7:0].
  - a=3 → VRR[15:8].
  - a=1 → 8'h00.
- FSM states: IDLE, WRITE, READ.
  - IDLE→WRITE or READ when an access starts. vram_req=1, and vram_addr/vram_we/vram_wdata are loaded the same edge and held stable until ack.
  - WRITE: on vram_ack, MAWR<=vram_addr+inc, then go to IDLE. A write to MAWR during WRITE is overridden by this post-increment.
  - READ: on vram_ack, VRR<=vram_rdata, then go to IDLE. MARR is unchanged by ack.
  - vram_req drops the cycle after ack.
- busy_n = (state==IDLE).
- Start while not IDLE: the VRAM access is dropped. Register updates and reg_we still occur.
- Reset values: dout=0, busy_n=1, status_rd=0, reg_we=0, reg_addr=0, reg_wdata=0, vram_req=0, vram_we=0, vram_addr=0, vram_wdata=0. AR, lo, MAWR, MARR, VRR and inc_sel are all 0.
- Reset mid-access: vram_req deasserts immediately (asynchronously) and the FSM returns to IDLE.

Optional Feature:
- Macro: VDC_PORT_ERR_EN.
- Defined:
  - Adds output err (1 bit, reset 0).
  - err sets sticky on any dropped start.
  - err clears on a write event with a_q=1, din_q[0]=1.
- Undefined: no err port; drops are silent.

Test Plan:
- Write a=0 din=0x00, a=2 0x34, a=3 0x12 → reg_we pulse reg_addr=0 reg_wdata=0x1234; MAWR=0x1234.
- AR=2, write lo=0xCD, hi=0xAB, ack after 3 cycles → vram_req high 3 cycles, addr=0x1234, wdata=0xABCD, we=1, busy_n low throughout; MAWR=0x1235 afterward.
- AR=5 commit 0x1000 (inc_sel=10), then VRAM write with MAWR=0xFFF0 → MAWR=0x0030 after ack (wrap).
- AR=1 commit 0x0200, ack with rdata=0xBEEF → VRR=0xBEEF. Then rd a=2 → dout=0xEF; rd a=3 → dout=0xBE, MARR=0x0201, new read req at 0x0201.
- VRAM write pending, second AR=2 commit before ack → second access dropped, reg_we still pulses, only one vram_req transaction. With VDC_PORT_ERR_EN: err=1, cleared by writing a=1 0x01.
- Assert reset_n low during READ with vram_req=1 → vram_req=0 and busy_n=1 immediately; all registers 0.
